pp_pipeline_accel_fifo_frame_reader: RTL
========================================

Name: pp_pipeline_accel_fifo_frame_reader

Overview:
- Read-side consumer of a pp_pipeline_accel FIFO (first-word-fall-through handshake: empty_n/read/dout).
- Drains a programmed frame of cfg_rows x cfg_cols words and emits it as an AXI4-Stream master.
- Marks the first beat of each frame with TUSER and the last beat of each row with TLAST.
- Sits between the HLS pipeline output FIFO and the DMA/VDMA stream port.

Parameters:
- DATA_WIDTH, 32, width of FIFO word and TDATA.
- DIM_WIDTH, 16, width of row/column size and counters.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
- cfg_cols  input  DIM_WIDTH  words per row; latched on accepted start.
- cfg_rows  input  DIM_WIDTH  rows per frame; latched on accepted start.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at frame completion.
- if_empty_n  input  1  FIFO has valid data on if_dout.
- if_read  output  1  pop FIFO this cycle.
- if_read_ce  output  1  constant 1.
- if_dout  input  DATA_WIDTH  FIFO head word, valid when if_empty_n=1.
- m_axis_tdata  output  DATA_WIDTH  stream data.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready.
- m_axis_tlast  output  1  last beat of row.
- m_axis_tuser  output  1  first beat of frame.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state is cleared on reset.
- Reset values: busy=0, done=0, if_read=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0. State is IDLE and all counters are 0.
- States:
  - IDLE: on start=1, latch cfg, clear counters, then:
    - if cfg_cols==0 or cfg_rows==0, go to DONE (no beats issued);
    - otherwise go to RUN.
  - RUN: fetch words until cols*rows have been popped, then go to DRAIN.
  - DRAIN: wait until the output register empties (tvalid=0, or tvalid&tready this cycle), then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in RUN, DRAIN and DONE.
- start outside IDLE is ignored.
- cfg changes after an accepted start have no effect on the current frame.
- Fetch rule (combinational): if_read = (state==RUN) & if_empty_n & (!m_axis_tvalid | m_axis_tready).
- if_read is never asserted when if_empty_n=0, and never after the final word of the frame has been popped.
- Output register: on if_read, load tdata<=if_dout and set tvalid<=1.
  - tlast <= (col_cnt==cols-1).
  - tuser <= (col_cnt==0 & row_cnt==0).
  - Otherwise, if tready, clear tvalid, tlast and tuser.
- Data must stay stable while tvalid=1 and tready=0 (AXI rule).
- Latency: FIFO pop to tvalid is 1 cycle. Sustained throughput is 1 beat/clk when the FIFO is non-empty and tready=1.
- Counters:
  - col_cnt increments per pop and wraps to 0 at cols-1; row_cnt increments on that wrap.
  - The final pop is col_cnt==cols-1 & row_cnt==rows-1.
  - Counters are unsigned DIM_WIDTH and never exceed cols-1 / rows-1.
- Boundaries:
  - cols=1: every beat has tlast=1; the first beat also has tuser=1.
  - Maximum dimensions (2^DIM_WIDTH-1) must work without overflow.
  - FIFO empty mid-row: tvalid drops after the pending beat is accepted; the row and column position is preserved.
  - Simultaneous pop and accept: the register reloads and tvalid stays 1.
- Reset mid-frame: the outstanding beat is discarded and tvalid=0 on the next cycle. Unread FIFO words remain in the FIFO (no auto-drain). done is not pulsed.

Test Plan:
- Frame cols=4, rows=2, FIFO preloaded with 1..8, tready=1 -> 8 beats on consecutive cycles, data 1..8; tuser only on beat 1; tlast on beats 4 and 8; done pulses 1 cycle after beat 8 is accepted; 8 if_read pulses total.
- Same frame with tready toggling 1,0,0,1,... -> no data loss or duplication; tdata/tlast/tuser stable while stalled; if_read=0 whenever tvalid=1 and tready=0.
- Frame cols=3, rows=3, FIFO empty for 5 cycles after word 4 -> tvalid low during the gap; beat 5 (0x5) is the next beat, with tlast only on beats 3, 6, 9; done after beat 9.
- cfg_cols=0, rows=5, start -> no if_read and no tvalid; busy high 1 cycle, done pulse 1 cycle later; 10 words in the FIFO untouched.
- Reset asserted after beat 3 of a 4x4 frame -> next cycle tvalid=0, busy=0, no done pulse; a fresh start with cols=2, rows=1 issues 2 beats with tuser on the first.
- start pulsed while busy, with different cfg -> ignored; the current frame completes with its original size; exactly one done pulse.

Source files
------------

// File: rtl/pp_pipeline_accel_fifo_frame_reader.sv
// Drains a cfg_rows x cfg_cols frame from a first-word-fall-through FIFO and
// emits it as an AXI4-Stream master with TUSER on the first beat and TLAST per row.
module pp_pipeline_accel_fifo_frame_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cfg_cols,
    input  logic [DIM_WIDTH-1:0]  cfg_rows,
    output logic                  busy,
    output logic                  done,
    input  logic                  if_empty_n,
    output logic                  if_read,
    output logic                  if_read_ce,
    input  logic [DATA_WIDTH-1:0] if_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DIM_WIDTH-1:0] DIM_ZERO = {DIM_WIDTH{1'b0}};
    localparam logic [DIM_WIDTH-1:0] DIM_ONE  = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic [DIM_WIDTH-1:0] cols;
    logic [DIM_WIDTH-1:0] rows;
    logic [DIM_WIDTH-1:0] col_cnt;
    logic [DIM_WIDTH-1:0] row_cnt;
    logic                 last_col;
    logic                 last_pop;
    logic                 first_pos;
    logic                 out_free;

    assign if_read_ce = 1'b1;

    // Position decode and the pop decision; a pop is only allowed when the
    // output register is empty or being emptied this cycle.
    always_comb begin
        last_col  = (col_cnt == (cols - DIM_ONE));
        last_pop  = last_col && (row_cnt == (rows - DIM_ONE));
        first_pos = (col_cnt == DIM_ZERO) && (row_cnt == DIM_ZERO);
        out_free  = !m_axis_tvalid || m_axis_tready;
        if (state == RUN) begin
            if_read = if_empty_n && out_free;
        end else begin
            if_read = 1'b0;
        end
    end

    // Frame control FSM with registered busy/done and the frame position counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cols    <= DIM_ZERO;
            rows    <= DIM_ZERO;
            col_cnt <= DIM_ZERO;
            row_cnt <= DIM_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        cols    <= cfg_cols;
                        rows    <= cfg_rows;
                        col_cnt <= DIM_ZERO;
                        row_cnt <= DIM_ZERO;
                        busy    <= 1'b1;
                        // An empty frame completes without touching the FIFO.
                        if ((cfg_cols == DIM_ZERO) || (cfg_rows == DIM_ZERO)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    done <= 1'b0;
                    busy <= 1'b1;
                    if (if_read) begin
                        if (last_pop) begin
                            col_cnt <= DIM_ZERO;
                            row_cnt <= DIM_ZERO;
                            state   <= DRAIN;
                        end else if (last_col) begin
                            col_cnt <= DIM_ZERO;
                            row_cnt <= row_cnt + DIM_ONE;
                        end else begin
                            col_cnt <= col_cnt + DIM_ONE;
                        end
                    end
                end
                DRAIN: begin
                    busy <= 1'b1;
                    if (out_free) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Stream output register: reloads on every pop, otherwise empties on accept
    // and holds its contents while the sink stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tdata  <= {DATA_WIDTH{1'b0}};
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (if_read) begin
            m_axis_tdata  <= if_dout;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= last_col;
            m_axis_tuser  <= first_pos;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end
    end

endmodule
